// File: rtl/dk_trigger_seq_pkg.sv
// Shared types and constants for the trigger sequencer.
// Holds the per-channel state encoding and the audio offset-binary constant.
package dk_trigger_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_FIN  = 2'd3
   } chan_state_e;

   localparam logic [15:0] SAMPLE_OFFSET = 16'h8000;

   // Signed two's-complement sample to offset-binary.
   function automatic logic [15:0] to_offset_binary(input logic [15:0] s);
      return s ^ SAMPLE_OFFSET;
   endfunction

endpackage

// File: rtl/dk_trigger_chan.sv
// One trigger channel: repeats a high/low pulse pattern counted in audio strobes.
// Parameters are latched on start and held until the sequence finishes or is stopped.
module dk_trigger_chan
   import dk_trigger_seq_pkg::*;
#(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned REP_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             strobe_i,
   input  logic [CNT_W-1:0] high_time_i,
   input  logic [CNT_W-1:0] low_time_i,
   input  logic [REP_W-1:0] repeats_i,
   output logic             trig_o,
   output logic             done_o,
   output logic             active_c
);

   chan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic             trig_q, trig_d;
   logic             done_q, done_d;
   logic             last_rep;
   logic             terminal;

   assign last_rep = (rep_q == REP_W'(1));
   assign terminal = strobe_i && (cnt_q <= CNT_W'(1));

   // Next-state and counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      high_d  = high_q;
      low_d   = low_q;
      rep_d   = rep_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               high_d = high_time_i;
               low_d  = low_time_i;
               rep_d  = repeats_i;
               if ((repeats_i == '0) || ((high_time_i == '0) && (low_time_i == '0))) begin
                  state_d = ST_FIN;
               end else if (high_time_i == '0) begin
                  state_d = ST_LOW;
                  cnt_d   = low_time_i;
               end else begin
                  state_d = ST_HIGH;
                  cnt_d   = high_time_i;
               end
            end
         end
         ST_HIGH: begin
            if (terminal) begin
               if (low_q == '0) begin
                  // No low phase: the high phase itself closes a repeat.
                  rep_d = rep_q - REP_W'(1);
                  if (last_rep) begin
                     state_d = ST_FIN;
                  end else begin
                     cnt_d = high_q;
                  end
               end else begin
                  state_d = ST_LOW;
                  cnt_d   = low_q;
               end
            end else if (strobe_i) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_LOW: begin
            if (terminal) begin
               rep_d = rep_q - REP_W'(1);
               if (last_rep) begin
                  state_d = ST_FIN;
               end else if (high_q != '0) begin
                  state_d = ST_HIGH;
                  cnt_d   = high_q;
               end else begin
                  cnt_d = low_q;
               end
            end else if (strobe_i) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (stop_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end

      trig_d   = (state_d == ST_HIGH);
      done_d   = (state_q == ST_FIN) && !stop_i;
      active_c = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         high_q  <= '0;
         low_q   <= '0;
         rep_q   <= '0;
         trig_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         high_q  <= high_d;
         low_q   <= low_d;
         rep_q   <= rep_d;
         trig_q  <= trig_d;
         done_q  <= done_d;
      end
   end

   assign trig_o = trig_q;
   assign done_o = done_q;

endmodule

// File: rtl/dk_trigger_seq.sv
// Multi-channel trigger sequencer with a shared audio-strobe divider and
// an offset-binary sample path registered on each strobe.
module dk_trigger_seq
   import dk_trigger_seq_pkg::*;
#(
   parameter int unsigned CLOCK_RATE  = 1536000,
   parameter int unsigned SAMPLE_RATE = 96000,
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned REP_W       = 8
) (
   input  logic                      clk,
   input  logic                      I_RST,
   input  logic                      start,
   input  logic                      stop,
   input  logic [CHANNELS*CNT_W-1:0] high_time,
   input  logic [CHANNELS*CNT_W-1:0] low_time,
   input  logic [CHANNELS*REP_W-1:0] repeats,
   input  logic [15:0]               sample_in,
   output logic                      audio_clk_en,
   output logic [CHANNELS-1:0]       trig,
   output logic                      busy,
   output logic [CHANNELS-1:0]       done,
   output logic [15:0]               sample_out,
   output logic                      sample_valid
);

   localparam int unsigned DIV   = CLOCK_RATE / SAMPLE_RATE;
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   if (DIV < 2) begin : g_bad_div
      $error("dk_trigger_seq: CLOCK_RATE/SAMPLE_RATE must be at least 2");
   end
   if ((CHANNELS < 1) || (CHANNELS > 8)) begin : g_bad_channels
      $error("dk_trigger_seq: CHANNELS must be 1..8");
   end

   logic [DIV_W-1:0]    div_q, div_d;
   logic                en_q, en_d;
   logic [15:0]         sample_q, sample_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic [CHANNELS-1:0] active_c;

   // Free-running strobe divider and sample capture.
   always_comb begin
      div_d    = div_q + DIV_W'(1);
      en_d     = 1'b0;
      sample_d = sample_q;
      valid_d  = en_q;
      busy_d   = |active_c;
      if (div_q == DIV_W'(DIV - 1)) begin
         div_d = '0;
         en_d  = 1'b1;
      end
      if (en_q) begin
         sample_d = to_offset_binary(sample_in);
      end
   end

   always_ff @(posedge clk or posedge I_RST) begin
      if (I_RST) begin
         div_q    <= '0;
         en_q     <= 1'b0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         div_q    <= div_d;
         en_q     <= en_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      dk_trigger_chan #(
         .CNT_W(CNT_W),
         .REP_W(REP_W)
      ) u_chan (
         .clk        (clk),
         .rst        (I_RST),
         .start_i    (start),
         .stop_i     (stop),
         .strobe_i   (en_q),
         .high_time_i(high_time[k*CNT_W +: CNT_W]),
         .low_time_i (low_time[k*CNT_W +: CNT_W]),
         .repeats_i  (repeats[k*REP_W +: REP_W]),
         .trig_o     (trig[k]),
         .done_o     (done[k]),
         .active_c   (active_c[k])
      );
   end

   assign audio_clk_en = en_q;
   assign busy         = busy_q;
   assign sample_out   = sample_q;
   assign sample_valid = valid_q;

endmodule

// File: tb/tb_dk_trigger_seq.sv
// Self-checking bench for dk_trigger_seq: a strobe-count model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dk_trigger_seq;

   localparam int unsigned CH  = 2;
   localparam int unsigned CW  = 16;
   localparam int unsigned RW  = 8;
   localparam int          DIV = 16;

   logic              clk = 1'b0;
   logic              I_RST;
   logic              start;
   logic              stop;
   logic [CH*CW-1:0]  high_time;
   logic [CH*CW-1:0]  low_time;
   logic [CH*RW-1:0]  repeats;
   logic [15:0]       sample_in;
   logic              audio_clk_en;
   logic [CH-1:0]     trig;
   logic              busy;
   logic [CH-1:0]     done;
   logic [15:0]       sample_out;
   logic              sample_valid;

   always #5 clk = ~clk;

   dk_trigger_seq #(
      .CLOCK_RATE (1536000),
      .SAMPLE_RATE(96000),
      .CHANNELS   (CH),
      .CNT_W      (CW),
      .REP_W      (RW)
   ) dut (
      .clk         (clk),
      .I_RST       (I_RST),
      .start       (start),
      .stop        (stop),
      .high_time   (high_time),
      .low_time    (low_time),
      .repeats     (repeats),
      .sample_in   (sample_in),
      .audio_clk_en(audio_clk_en),
      .trig        (trig),
      .busy        (busy),
      .done        (done),
      .sample_out  (sample_out),
      .sample_valid(sample_valid)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // Model: a channel is active for repeats*(high+low) strobes after start;
   // trig is high while (strobes elapsed mod period) < high.
   int          e_m;
   logic        en_m;
   logic [15:0] so_m;
   logic        sv_m;
   logic        busy_m;
   logic [CH-1:0] done_m;
   int          n_m [CH];
   int          tot_m [CH];
   int          per_m [CH];
   int          hi_m [CH];
   bit          act_m [CH];
   bit          fin_m [CH];

   always @(posedge clk or posedge I_RST) begin
      logic strobe;
      if (I_RST) begin
         e_m = 0; en_m = 1'b0; so_m = '0; sv_m = 1'b0; busy_m = 1'b0; done_m = '0;
         for (int k = 0; k < CH; k++) begin
            n_m[k] = 0; tot_m[k] = 0; per_m[k] = 0; hi_m[k] = 0;
            act_m[k] = 1'b0; fin_m[k] = 1'b0;
         end
      end else begin
         strobe = en_m;
         busy_m = 1'b0;
         for (int k = 0; k < CH; k++) begin
            done_m[k] = fin_m[k] && !stop;
            if (stop) begin
               act_m[k] = 1'b0;
               fin_m[k] = 1'b0;
            end else if (fin_m[k]) begin
               fin_m[k] = 1'b0;
            end else if (act_m[k]) begin
               if (strobe) begin
                  n_m[k]++;
                  if (n_m[k] == tot_m[k]) begin
                     act_m[k] = 1'b0;
                     fin_m[k] = 1'b1;
                  end
               end
            end else if (start) begin
               hi_m[k]  = int'(high_time[k*CW +: CW]);
               per_m[k] = hi_m[k] + int'(low_time[k*CW +: CW]);
               tot_m[k] = per_m[k] * int'(repeats[k*RW +: RW]);
               n_m[k]   = 0;
               if (tot_m[k] == 0) fin_m[k] = 1'b1;
               else act_m[k] = 1'b1;
            end
            if (act_m[k] || fin_m[k]) busy_m = 1'b1;
         end
         if (strobe) so_m = sample_in + 16'd32768;
         sv_m = strobe;
         e_m++;
         en_m = ((e_m % DIV) == 0);
      end
   end

   always @(negedge clk) begin
      logic [CH-1:0] trig_e;
      for (int k = 0; k < CH; k++) begin
         trig_e[k] = act_m[k] && (per_m[k] > 0) && ((n_m[k] % per_m[k]) < hi_m[k]);
      end
      chk("audio_clk_en", 32'(audio_clk_en), 32'(en_m));
      chk("trig", 32'(trig), 32'(trig_e));
      chk("done", 32'(done), 32'(done_m));
      chk("busy", 32'(busy), 32'(busy_m));
      chk("sample_out", 32'(sample_out), 32'(so_m));
      chk("sample_valid", 32'(sample_valid), 32'(sv_m));
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_en(input string name);
      int i;
      i = 0;
      while (audio_clk_en !== 1'b1 && i < 64) begin
         @(negedge clk);
         i++;
      end
      if (audio_clk_en !== 1'b1) timeout(name);
   endtask

   task automatic set_ch(input int k, input int h, input int l, input int r);
      high_time[k*CW +: CW] = CW'(h);
      low_time[k*CW +: CW]  = CW'(l);
      repeats[k*RW +: RW]   = RW'(r);
   endtask

   initial begin
      logic [9:0] pat;
      int cnt, cnt1, first;

      I_RST = 1'b0; start = 1'b0; stop = 1'b0;
      high_time = '0; low_time = '0; repeats = '0; sample_in = '0;
      #1 I_RST = 1'b1;
      tick(3);
      chk("reset_outs", 32'({audio_clk_en, trig, busy, done, sample_out, sample_valid}), 32'd0);
      I_RST = 1'b0;

      // Basic pattern on ch0, immediate completion on ch1.
      set_ch(0, 2, 3, 2);
      set_ch(1, 5, 5, 0);
      wait_en("align_a");
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ch1_done_clk1", 32'(done[1]), 32'd0);
      tick();
      chk("ch1_done_clk2", 32'(done[1]), 32'd1);
      tick();
      chk("ch1_done_clk3", 32'(done[1]), 32'd0);
      cnt = 0;
      pat = '0;
      for (int i = 0; i < 400 && cnt < 10; i++) begin
         if (audio_clk_en) begin
            pat[9-cnt] = trig[0];
            cnt++;
         end
         tick();
      end
      if (cnt < 10) timeout("pattern_capture");
      chk("trig0_pattern", 32'(pat), 32'(10'b1100011000));
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (done[0]) cnt++;
         tick();
      end
      chk("ch0_done_count", 32'(cnt), 32'd1);
      chk("busy_after_done", 32'(busy), 32'd0);

      // Sample path.
      sample_in = 16'hFFFF;
      wait_en("sample_en1");
      tick();
      chk("sample_neg1", 32'(sample_out), 32'h7FFF);
      chk("valid_1", 32'(sample_valid), 32'd1);
      sample_in = 16'h7FFF;
      wait_en("sample_en2");
      tick();
      chk("sample_7fff", 32'(sample_out), 32'hFFFF);
      chk("valid_2", 32'(sample_valid), 32'd1);
      tick();
      chk("valid_drop", 32'(sample_valid), 32'd0);
      chk("sample_hold", 32'(sample_out), 32'hFFFF);

      // Stop during HIGH; ch1 has zero durations.
      set_ch(0, 4, 4, 3);
      set_ch(1, 0, 0, 3);
      wait_en("align_b");
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("stop_pre_trig", 32'(trig[0]), 32'd1);
      chk("stop_pre_busy", 32'(busy), 32'd1);
      tick();
      chk("zero_dur_done", 32'(done[1]), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_trig", 32'(trig[0]), 32'd0);
      chk("stop_busy", 32'(busy), 32'd0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done != '0) cnt++;
         tick();
      end
      chk("stop_no_done", 32'(cnt), 32'd0);
      set_ch(0, 1, 1, 1);
      set_ch(1, 0, 3, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 0;
      cnt1 = 0;
      for (int i = 0; i < 100; i++) begin
         if (done[0]) cnt++;
         if (done[1]) cnt1++;
         tick();
      end
      chk("relatch_done0", 32'(cnt), 32'd1);
      chk("relatch_done1", 32'(cnt1), 32'd1);

      // Reset mid-LOW.
      set_ch(0, 1, 5, 2);
      set_ch(1, 0, 0, 0);
      wait_en("align_c");
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_en("rst_strobe1");
      chk("rst_pre_high", 32'(trig[0]), 32'd1);
      tick();
      wait_en("rst_strobe2");
      chk("rst_pre_low", 32'(busy), 32'd1);
      @(posedge clk);
      #2 I_RST = 1'b1;
      #1 chk("rst_async_outs", 32'({audio_clk_en, trig, busy, done, sample_out, sample_valid}), 32'd0);
      tick(2);
      I_RST = 1'b0;
      first = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (audio_clk_en && first == 0) first = i;
      end
      chk("first_en_after_rst", 32'(first), 32'(DIV));

      // Start held high: re-arms after each completion; start+stop leaves idle.
      set_ch(0, 1, 1, 1);
      set_ch(1, 2, 0, 2);
      start = 1'b1;
      cnt = 0;
      for (int i = 0; i < 150; i++) begin
         if (done[0]) cnt++;
         tick();
      end
      chk("rearm_runs", 32'(cnt >= 4), 32'd1);
      stop = 1'b1;
      tick();
      chk("start_stop_busy1", 32'(busy), 32'd0);
      tick(3);
      chk("start_stop_busy2", 32'(busy), 32'd0);
      stop = 1'b0;
      start = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
